// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave: FSM state encoding and frame geometry.
package spi_reg_pkg;

  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] ADDR_BITS  = 5'd8;
  localparam logic [CNT_W-1:0] FRAME_BITS = 5'd24;
  localparam int               READ_FLAG_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_DATA_WR = 3'd2,
    ST_DATA_RD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/spi_reg_slave_if.sv
// Register-bus side of the SPI slave: single-cycle read/write strobes toward the register bank.
interface spi_reg_slave_if #(
  parameter int p_WIDTH_ADDR = 8,
  parameter int p_WIDTH_DATA = 16
);

  logic [p_WIDTH_ADDR-1:0] addr;
  logic [p_WIDTH_DATA-1:0] wdata;
  logic                    wen;
  logic                    ren;
  logic [p_WIDTH_DATA-1:0] rdata;

  modport master (output addr, output wdata, output wen, output ren, input rdata);
  modport slave  (input addr, input wdata, input wen, input ren, output rdata);

endinterface

// File: rtl/spi_in_sync.sv
// N-stage synchronizer for one asynchronous SPI pin, plus edge detect against a delayed copy.
module spi_in_sync #(
  parameter int p_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [p_SYNC_STAGES-1:0] sync_q;
  logic                     q_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      q_dly  <= 1'b0;
    end else begin
      sync_q <= {sync_q[p_SYNC_STAGES-2:0], d};
      q_dly  <= sync_q[p_SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[p_SYNC_STAGES-1];
  assign rise = q & ~q_dly;
  assign fall = ~q & q_dly;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that turns one address byte plus one data word into a single register-bus strobe.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int p_WIDTH_ADDR  = 8,
  parameter int p_WIDTH_DATA  = 16,
  parameter int p_SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic             spi_miso_oe,
  output logic             frame_err,
  spi_reg_slave_if.master  bus
);

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic cs_n_s, cs_rise_unused, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_in_sync #(.p_SYNC_STAGES(p_SYNC_STAGES)) u_sync_sclk (
    .clk (clk), .rst (rst), .d (spi_sclk),
    .q (sclk_lvl_unused), .rise (sclk_rise), .fall (sclk_fall)
  );

  spi_in_sync #(.p_SYNC_STAGES(p_SYNC_STAGES)) u_sync_cs (
    .clk (clk), .rst (rst), .d (spi_cs_n),
    .q (cs_n_s), .rise (cs_rise_unused), .fall (cs_fall)
  );

  spi_in_sync #(.p_SYNC_STAGES(p_SYNC_STAGES)) u_sync_mosi (
    .clk (clk), .rst (rst), .d (spi_mosi),
    .q (mosi_s), .rise (mosi_rise_unused), .fall (mosi_fall_unused)
  );

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q;
  logic [p_WIDTH_DATA-1:0] rx_sr_q;
  logic [p_WIDTH_DATA-1:0] tx_sr_q;
  logic [p_WIDTH_ADDR-1:0] addr_q;
  logic [p_WIDTH_DATA-1:0] wdata_q;
  logic                    wen_q, ren_q, frame_err_q, miso_q;
  logic                    cs_seen_high_q;
  logic                    wen_d, ren_d, frame_err_d, addr_ld;
  logic                    in_frame;

  assign in_frame = (state_q == ST_ADDR) || (state_q == ST_DATA_WR) || (state_q == ST_DATA_RD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // A fall only starts a frame once CS_N has been seen high since reset, so a
  // reset in the middle of a frame drops the rest of that frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_seen_high_q && cs_fall) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (cs_n_s)                       state_d = ST_IDLE;
        else if (bit_cnt_q == ADDR_BITS)  state_d = rx_sr_q[READ_FLAG_BIT] ? ST_DATA_RD : ST_DATA_WR;
      end
      ST_DATA_WR, ST_DATA_RD: begin
        if (bit_cnt_q == FRAME_BITS) state_d = ST_DONE;
        else if (cs_n_s)             state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (cs_n_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    frame_err_d = 1'b0;
    addr_ld     = 1'b0;
    unique case (state_q)
      ST_ADDR: begin
        if (cs_n_s) begin
          frame_err_d = 1'b1;
        end else if (bit_cnt_q == ADDR_BITS) begin
          addr_ld = 1'b1;
          ren_d   = rx_sr_q[READ_FLAG_BIT];
        end
      end
      ST_DATA_WR: begin
        if (bit_cnt_q == FRAME_BITS) wen_d = 1'b1;
        else if (cs_n_s)             frame_err_d = 1'b1;
      end
      ST_DATA_RD: begin
        if ((bit_cnt_q != FRAME_BITS) && cs_n_s) frame_err_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q      <= '0;
      rx_sr_q        <= '0;
      tx_sr_q        <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wen_q          <= 1'b0;
      ren_q          <= 1'b0;
      frame_err_q    <= 1'b0;
      miso_q         <= 1'b0;
      cs_seen_high_q <= 1'b0;
    end else begin
      wen_q          <= wen_d;
      ren_q          <= ren_d;
      frame_err_q    <= frame_err_d;
      cs_seen_high_q <= cs_seen_high_q | cs_n_s;
      if (addr_ld) addr_q  <= rx_sr_q[p_WIDTH_ADDR-1:0];
      if (wen_d)   wdata_q <= rx_sr_q;

      if (state_q == ST_IDLE) begin
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
        tx_sr_q   <= '0;
        miso_q    <= 1'b0;
      end else begin
        // Counting stops at a full frame; later SCLK rises are ignored.
        if (in_frame && sclk_rise && (bit_cnt_q != FRAME_BITS)) begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
          rx_sr_q   <= {rx_sr_q[p_WIDTH_DATA-2:0], mosi_s};
        end
        // rdata is only valid alongside ren, so the TX word is captured on that cycle.
        if (ren_q) begin
          tx_sr_q <= bus.rdata;
        end else if ((state_q == ST_DATA_RD) && sclk_fall) begin
          miso_q  <= tx_sr_q[p_WIDTH_DATA-1];
          tx_sr_q <= {tx_sr_q[p_WIDTH_DATA-2:0], 1'b0};
        end
      end
    end
  end

  assign spi_miso    = miso_q & (state_q == ST_DATA_RD);
  assign spi_miso_oe = cs_seen_high_q & ~cs_n_s;
  assign frame_err   = frame_err_q;

  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wen   = wen_q;
  assign bus.ren   = ren_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: an MCU-style SPI master drives frames while a frame-outcome model predicts bus strobes.
module tb_spi_reg_slave;

  localparam int HALF = 8;  // SCLK = clk/16
  localparam int K_WR = 0;
  localparam int K_RD = 1;
  localparam int K_AB = 2;

  logic clk = 1'b0;
  logic rst, spi_sclk, spi_cs_n, spi_mosi;
  logic spi_miso, spi_miso_oe, frame_err;

  always #5 clk = ~clk;

  spi_reg_slave_if #(.p_WIDTH_ADDR(8), .p_WIDTH_DATA(16)) bus ();

  spi_reg_slave #(.p_WIDTH_ADDR(8), .p_WIDTH_DATA(16), .p_SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .frame_err   (frame_err),
    .bus         (bus)
  );

  logic [15:0] rd_mem [256];
  assign bus.rdata = rd_mem[bus.addr];

  typedef struct {
    int          kind;
    logic [7:0]  a;
    logic [15:0] d;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          n_ren = 0;
  int          n_ferr = 0;
  logic [7:0]  last_w_addr = 8'h00;
  logic [15:0] last_w_data = 16'h0000;
  logic [7:0]  model_addr = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int head_kind();
    return (exp_q.size() != 0) ? exp_q[0].kind : -1;
  endfunction

  // Every strobe the DUT emits must match the next predicted frame outcome.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wen || bus.ren) chk("strobe_exclusive", {31'd0, bus.wen & bus.ren}, 32'd0);
      if (bus.wen) begin
        chk("wen_expected", head_kind(), K_WR);
        if (head_kind() == K_WR) begin
          chk("wen_addr", bus.addr, exp_q[0].a);
          chk("wen_wdata", bus.wdata, exp_q[0].d);
          void'(exp_q.pop_front());
        end
        last_w_addr = bus.addr;
        last_w_data = bus.wdata;
      end
      if (bus.ren) begin
        n_ren++;
        chk("ren_expected", head_kind(), K_RD);
        if (head_kind() == K_RD) begin
          chk("ren_addr", bus.addr, exp_q[0].a);
          void'(exp_q.pop_front());
        end
      end
      if (frame_err) begin
        n_ferr++;
        chk("ferr_expected", head_kind(), K_AB);
        if (head_kind() == K_AB) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_miso"}, spi_miso, 0);
    chk({tag, "_oe"}, spi_miso_oe, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_addr"}, bus.addr, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_wen"}, bus.wen, 0);
    chk({tag, "_ren"}, bus.ren, 0);
  endtask

  // Outcome of a frame follows only from its address byte and how many SCLK rises it got.
  task automatic predict(input logic [7:0] a, input logic [15:0] d, input int nbits);
    exp_t e;
    e.a = a;
    e.d = d;
    if (nbits < 8) begin
      e.kind = K_AB; exp_q.push_back(e);
      return;
    end
    model_addr = a;
    if (a[7]) begin
      e.kind = K_RD; exp_q.push_back(e);
    end
    if (nbits < 24) begin
      e.kind = K_AB; exp_q.push_back(e);
    end else if (!a[7]) begin
      e.kind = K_WR; exp_q.push_back(e);
    end
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [15:0] d, input int nbits,
                           input int rst_at, output logic [15:0] miso_word);
    logic [31:0] stream;
    logic        extra;
    stream    = {a, d, 8'hFF};
    miso_word = '0;
    extra     = 1'b0;
    if (rst_at < 0) predict(a, d, nbits);
    spi_cs_n = 1'b0;
    spi_mosi = stream[31];
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_sclk = 1'b1;
      if (i == 0) chk("oe_in_frame", spi_miso_oe, 1);
      if (i >= 8 && i < 24) miso_word = {miso_word[14:0], spi_miso};
      if (i >= 24) extra = extra | spi_miso;
      wait_clk(HALF);
      spi_sclk = 1'b0;
      if (i + 1 < 32) spi_mosi = stream[30-i];
      if (i + 1 == rst_at) begin
        rst = 1'b1;
        #1;
        check_outputs_zero("midrst");
        model_addr = 8'h00;
        wait_clk(2);
        rst = 1'b0;
      end
      wait_clk(HALF);
    end
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(4 * HALF);
    chk("frame_outcomes_done", exp_q.size(), 0);
    chk("addr_held", bus.addr, model_addr);
    chk("oe_after_frame", spi_miso_oe, 0);
    if (nbits > 24) chk("miso_after_bit24", extra, 0);
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w;
    int          r0, e0;
    rst      = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    for (int i = 0; i < 256; i++) rd_mem[i] = 16'($urandom);
    rd_mem[8'h81] = 16'hABCD;
    wait_clk(3);
    check_outputs_zero("por");
    rst = 1'b0;
    wait_clk(10);
    chk("idle_oe", spi_miso_oe, 0);

    run_frame(8'h01, 16'h1234, 24, -1, w);
    chk("wr01_addr_lit", last_w_addr, 8'h01);
    chk("wr01_data_lit", last_w_data, 16'h1234);

    r0 = n_ren;
    run_frame(8'h81, 16'h0000, 24, -1, w);
    chk("rd81_miso_lit", w, 16'hABCD);
    chk("rd81_ren_once", n_ren - r0, 1);

    e0 = n_ferr;
    run_frame(8'h02, 16'hBEEF, 12, -1, w);
    chk("abort_ferr_once", n_ferr - e0, 1);
    chk("abort_addr_lit", bus.addr, 8'h02);
    run_frame(8'h03, 16'h5A5A, 24, -1, w);
    chk("wr03_data_lit", last_w_data, 16'h5A5A);

    run_frame(8'h04, 16'h00FF, 32, -1, w);
    chk("wr04_data_lit", last_w_data, 16'h00FF);

    run_frame(8'h05, 16'hCAFE, 24, 10, w);
    run_frame(8'h05, 16'h1111, 24, -1, w);
    chk("wr05_data_lit", last_w_data, 16'h1111);

    r0 = n_ren;
    e0 = n_ferr;
    run_frame(8'h80, 16'h0000, 24, -1, w);
    chk("rd80_miso", w, rd_mem[8'h80]);
    run_frame(8'h84, 16'h0000, 24, -1, w);
    chk("rd84_miso", w, rd_mem[8'h84]);
    chk("b2b_ren_count", n_ren - r0, 2);
    chk("b2b_no_ferr", n_ferr - e0, 0);

    for (int f = 0; f < 24; f++) begin
      logic [7:0]  ra;
      logic [15:0] rd;
      int          nb;
      ra = 8'($urandom);
      rd = 16'($urandom);
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 32)) : 24;
      run_frame(ra, rd, nb, -1, w);
      if (ra[7] && nb >= 24) chk("rnd_rd_miso", w, rd_mem[ra]);
    end

    chk("outcomes_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
SPI slave front end that turns MCU SPI frames into single-cycle register-bus transactions (addr/wdata/wen/ren/rdata) for the register bank. It sits between the MCU pins and the register bank, in the system clock domain. SCLK, CS_N and MOSI are oversampled. Each frame carries one address byte. A write frame then carries one data word from the MCU; a read frame carries one data word returned on MISO.

Parameters:
p_WIDTH_ADDR, 8, address byte width; addr MSB=1 means read (read base 0x80), MSB=0 means write
p_WIDTH_DATA, 16, data word width
p_SYNC_STAGES, 2, flip-flop stages on each SPI input synchronizer (minimum 2)

Ports:
clk  in  1  system clock; must be at least 8x the SCLK frequency
rst  in  1  asynchronous, active-high reset
spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_cs_n  in  1  chip select, active low
spi_mosi  in  1  serial data in, MSB first
spi_miso  out  1  serial data out, MSB first
spi_miso_oe  out  1  MISO output enable; 1 while CS_N is low (synchronized)
addr  out  p_WIDTH_ADDR  bus address; held from frame decode until the next frame's address byte
wdata  out  p_WIDTH_DATA  bus write data; valid while wen=1
wen  out  1  one-clk write strobe
ren  out  1  one-clk read strobe
rdata  in  p_WIDTH_DATA  bus read data; combinational from the bank and valid in the same cycle as ren
frame_err  out  1  one-clk pulse when a frame is aborted before completion

Behaviour:
- Reset (async, rst=1): all outputs are 0, FSM is in IDLE, counters and shift registers are cleared.
- Input synchronization: sclk, cs_n and mosi each pass through p_SYNC_STAGES flops.
  - An extra flop on sclk gives rise/fall edge detects in clk.
  - mosi is sampled on the detected SCLK rise.
- bit_cnt is a 5-bit counter of SCLK rises in the current frame. It saturates at 24.
- FSM states:
  - IDLE: wait for synchronized cs_n to go low -> ADDR. Clear bit_cnt and the shift registers.
  - ADDR: shift 8 MOSI bits into the address shift register. On the 8th rise, in the next clk cycle:
    - latch addr from the shift register;
    - if addr[7]=1: assert ren for exactly 1 cycle, load rdata into the TX shift register -> DATA_RD;
    - else -> DATA_WR.
  - DATA_WR: shift 16 MOSI bits. On the 24th rise, in the next clk cycle, assert wen for exactly 1 cycle with wdata set to the shifted word -> DONE.
  - DATA_RD: on each SCLK fall, drive spi_miso from TX[15] and shift left. The first fall after the address byte presents bit 15. After the 24th rise -> DONE.
  - DONE: ignore further SCLK activity and hold spi_miso at 0. Wait for cs_n high -> IDLE.
- spi_miso is 0 in IDLE, ADDR and DONE. spi_miso_oe equals the inverse of synchronized cs_n.
- ren and wen are never asserted in the same cycle. A read frame produces exactly one ren, so a FIFO pop happens exactly once per frame. A write frame produces exactly one wen.
- Abort: cs_n rising in ADDR, DATA_WR or DATA_RD -> IDLE.
  - Pulse frame_err for 1 cycle.
  - No wen. A ren already issued is not retracted.
  - addr holds its last value.
- CS_N high in DONE is a normal end of frame and raises no frame_err.
- Back-to-back frames: cs_n must be high for at least 2 SCLK periods between frames. A new cs_n fall is accepted only from IDLE.
- Extra bits: SCLK rises beyond 24 are ignored and bit_cnt stays saturated at 24.
- Reset mid-frame: everything is cleared immediately. The remainder of the frame is ignored until cs_n goes high and then falls again.
- Worst-case latency from the 8th/24th SCLK rise at the pin to ren/wen is p_SYNC_STAGES + 2 clk cycles.

Decomposition:
- Shared package spi_reg_pkg holds:
  - FSM state encoding (IDLE, ADDR, DATA_WR, DATA_RD, DONE);
  - the constants ADDR_BITS=8, FRAME_BITS=24 and READ_FLAG_BIT=7.
- One sub-module, spi_in_sync: an N-stage synchronizer with registered rise/fall detect, instantiated for sclk, cs_n and mosi (edge detect used for sclk and cs_n only).

Test Plan:
- Write frame: address 0x01, data 0x1234, SCLK = clk/16 -> one wen cycle with addr=0x01, wdata=0x1234; ren stays 0; frame_err stays 0.
- Read frame: address 0x81, rdata tied to 0xABCD -> one ren cycle with addr=0x81; MISO bits sampled on SCLK rises 9..24 read 0xABCD; exactly one ren per frame.
- Abort: address 0x02, then cs_n high after 12 bits -> no wen; frame_err pulses for 1 cycle; FSM returns to IDLE; the next full frame 0x03/0x5A5A writes correctly.
- Overlong frame: 0x04/0x00FF followed by 8 extra bits of 0xFF -> one wen with wdata=0x00FF; MISO stays 0 after bit 24; no second strobe.
- Reset mid-frame: rst pulsed after 10 bits of a write to 0x05 -> all outputs 0 immediately; no wen; the next frame 0x05/0x1111 produces wen with wdata=0x1111.
- Back-to-back reads: 0x80 then 0x84 with a 2-SCLK gap between them, rdata changing per address -> one ren per frame, correct MISO data for each, no frame_err.
